// File: rtl/cpu_pkg.sv
// Shared ALU opcodes, arbiter FSM states and opcode legality check.
package cpu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; the last-grant history is held by the caller.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_valid;
    // Contention: the requester that did not win last time goes next.
    if (i_valid == 2'b11) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, round-robin, returning
// each result on a single id-tagged response channel.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_read_data_1,
  output logic [DATA_W-1:0] alu_read_data_2,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  state_t              r_state;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [OP_W-1:0]     r_op;
  logic                r_id;
  logic                r_err;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp_err;

  logic [1:0]          w_grant;
  logic                w_hs;
  logic                w_hs_id;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [OP_W-1:0]     w_sel_op;
  logic                w_sel_legal;

  rr_arb2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Ready is only offered from IDLE and never while reset is asserted.
  assign req0_ready  = rst_n && (r_state == IDLE) && w_grant[0];
  assign req1_ready  = rst_n && (r_state == IDLE) && w_grant[1];
  assign w_hs        = req0_ready || req1_ready;
  assign w_hs_id     = req1_ready;
  assign w_sel_a     = w_hs_id ? req1_a  : req0_a;
  assign w_sel_b     = w_hs_id ? req1_b  : req0_b;
  assign w_sel_op    = w_hs_id ? req1_op : req0_op;
  assign w_sel_legal = is_legal_op(w_sel_op);

  assign alu_read_data_1 = r_a;
  assign alu_read_data_2 = r_b;
  assign alu_control     = r_op;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_id          = r_rsp_id;
  assign rsp_result      = r_rsp_result;
  assign rsp_zero        = r_rsp_zero;
  assign rsp_err         = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            // Illegal codes still occupy the ALU, but with a benign opcode.
            r_op         <= w_sel_legal ? w_sel_op : ALU_ADD;
            r_err        <= !w_sel_legal;
            r_id         <= w_hs_id;
            r_last_grant <= w_hs_id;
            r_state      <= EXEC;
          end
        end
        EXEC: r_state <= CAPT;
        CAPT: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_id;
          r_rsp_err    <= r_err;
          r_rsp_result <= r_err ? '0 : alu_result;
          r_rsp_zero   <= r_err ? 1'b0 : alu_zero;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
